combo_lock_seq: RTL
===================

COMBO_LOCK_SEQ -- requirements
Module: combo_lock_seq

Interface
REQ-001 Parameter NUM_STAGES, default 3: number of two-digit code entries per attempt; legal range 1..8.
REQ-002 Parameter CODE, default 24'h961928: expected codes, 8 bits per stage, stage 0 in bits [7:0] as {A,B}.
REQ-003 Parameter MAX_FAILS, default 3: failed attempts that trigger lockout; legal range 1..15.
REQ-004 Parameter ERR_CYCLES, default 4: clock cycles the error indication is held.
REQ-005 Parameter LOCKOUT_CYCLES, default 16: clock cycles of lockout.
REQ-006 clock  input  1  sole clock; all state updates on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 A  input  4  high digit of current entry.
REQ-009 B  input  4  low digit of current entry.
REQ-010 enter  input  1  level button; only its rising edge is acted on.
REQ-011 H1..H6  output  7 each  active-low seven-segment drives, bit0=a .. bit6=g.
REQ-012 unlocked  output  1  high while in UNLOCKED.
REQ-013 locked_out  output  1  high while in LOCKOUT.

Function
REQ-014 enter SHALL be registered into enter_q each cycle; edge = enter & ~enter_q; an edge is acted on at the next clock edge (1-cycle latency from sampled edge to state change).
REQ-015 States SHALL be ENTRY, UNLOCKED, ERROR, LOCKOUT.
REQ-016 ENTRY, edge with {A,B}==8'h00: stage<=0, match<=1, fail count unchanged (abort).
REQ-017 ENTRY, edge with {A,B}!=0 and stage<NUM_STAGES-1: match<=match & ({A,B}==CODE[stage]); stage<=stage+1.
REQ-018 ENTRY, edge with {A,B}!=0 at stage NUM_STAGES-1: if final match true -> UNLOCKED, fails<=0; else fails+1==MAX_FAILS -> LOCKOUT, else fails<=fails+1 and -> ERROR; in all cases stage<=0, match<=1.
REQ-019 Mismatch SHALL NOT be indicated before the final stage entry.
REQ-020 UNLOCKED: edge with {A,B}==0 -> ENTRY; other edges ignored.
REQ-021 ERROR: load timer ERR_CYCLES-1 on entry, decrement per cycle, at 0 -> ENTRY; edges ignored.
REQ-022 LOCKOUT: load timer LOCKOUT_CYCLES-1, decrement, at 0 -> ENTRY with fails<=0; edges ignored.
REQ-023 enter held high across a return to ENTRY SHALL NOT count as an edge.
REQ-024 H1=seg(B), H2=seg(A) combinationally in all states; H3=seg(stage) in ENTRY, blank otherwise.
REQ-025 H6,H5,H4 (active-high patterns, inverted at port): ENTRY blank; UNLOCKED O,P,n (3F,73,54); ERROR E,r,r (79,50,50); LOCKOUT L,O,C (38,3F,39); blank = 7'h7F at port.
REQ-026 stage width clog2(NUM_STAGES)+1 min 1; fails 4 bits, never exceeds MAX_FAILS-1 outside LOCKOUT; timer width sized to max(ERR_CYCLES,LOCKOUT_CYCLES).

Reset
REQ-027 reset SHALL force ENTRY, stage=0, match=1, fails=0, timer=0, enter_q=1 (no false edge), unlocked=0, locked_out=0, H3..H6 per ENTRY.
REQ-028 reset SHALL take priority over every event, including mid-ERROR, mid-LOCKOUT and an edge in the same cycle.

Structure
REQ-029 Package combo_lock_pkg SHALL hold the state enum and the O,P,n,E,r,L,C,blank segment constants.
REQ-030 Sub-module hex_to_seg7 (4-bit in, active-low 7-bit out, full 0-F table) SHALL be instantiated for H1, H2, H3.

Verification (defaults)
REQ-031 Edges with 28,19,96 -> unlocked=1 one cycle after third edge, H6..H4 = ~3F,~73,~54.
REQ-032 28,19,95 -> ERROR after third edge, unlocked=0, "Err" for 4 cycles, then ENTRY stage 0.
REQ-033 Three wrong attempts -> locked_out=1 for 16 cycles; edges during lockout ignored; fails=0 after.
REQ-034 28, then 00, then 28,19,96 -> abort resets stage to 0, unlock succeeds, fails unchanged by abort.
REQ-035 enter held high 10 cycles with 28 -> exactly one stage advance; unlocked then 00 edge -> ENTRY.
REQ-036 reset asserted mid-LOCKOUT with enter edge same cycle -> ENTRY, locked_out=0, no stage advance.

Source files
------------

// File: rtl/combo_lock_pkg.sv
// Shared types and display glyphs for the combination lock.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package combo_lock_pkg;

  typedef enum logic [1:0] {
    ST_ENTRY    = 2'd0,
    ST_UNLOCKED = 2'd1,
    ST_ERROR    = 2'd2,
    ST_LOCKOUT  = 2'd3
  } state_t;

  // Active-high segment patterns, bit0=a .. bit6=g; inverted at the ports.
  localparam logic [6:0] SEG_O     = 7'h3F;
  localparam logic [6:0] SEG_P     = 7'h73;
  localparam logic [6:0] SEG_N     = 7'h54;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_R     = 7'h50;
  localparam logic [6:0] SEG_L     = 7'h38;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/combo_lock_seq_hex_to_seg7.sv
// Hex nibble to active-low seven-segment decoder, bit0=a .. bit6=g.
// Latency: purely combinational.
// Backpressure: none.
module hex_to_seg7 (
  input  logic [3:0] hex,
  output logic [6:0] seg_n
);

  logic [6:0] seg;

  // Full 0-F glyph table in active-high form.
  always_comb begin
    seg = 7'h00;
    case (hex)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
  end

  assign seg_n = ~seg;

endmodule

// File: rtl/combo_lock_seq.sv
// Multi-stage two-digit combination lock with error hold and failed-attempt lockout.
// Latency: an enter rising edge changes state at the clock edge that samples it.
// Backpressure: none; edges arriving in ERROR/LOCKOUT (or non-zero in UNLOCKED) are dropped.
module combo_lock_seq
  import combo_lock_pkg::*;
#(
  parameter int                      NUM_STAGES     = 3,
  parameter logic [8*NUM_STAGES-1:0] CODE           = 24'h961928,
  parameter int                      MAX_FAILS      = 3,
  parameter int                      ERR_CYCLES     = 4,
  parameter int                      LOCKOUT_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       enter,
  output logic [6:0] H1,
  output logic [6:0] H2,
  output logic [6:0] H3,
  output logic [6:0] H4,
  output logic [6:0] H5,
  output logic [6:0] H6,
  output logic       unlocked,
  output logic       locked_out
);

  localparam int SW   = $clog2(NUM_STAGES) + 1;
  localparam int TMAX = (ERR_CYCLES > LOCKOUT_CYCLES) ? ERR_CYCLES : LOCKOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_STAGES - 1);
  localparam logic [3:0]    FAIL_LIMIT = 4'(MAX_FAILS);
  localparam logic [TW-1:0] ERR_LOAD   = TW'(ERR_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LOAD  = TW'(LOCKOUT_CYCLES - 1);

  state_t        state, state_nxt;
  logic [SW-1:0] stage, stage_nxt;
  logic          match, match_nxt;
  logic [3:0]    fails, fails_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic          enter_q;

  logic          enter_edge;
  logic [7:0]    ab;
  logic [7:0]    code_cur;
  logic          digit_ok;

  assign enter_edge = enter & ~enter_q;
  assign ab         = {A, B};
  assign digit_ok   = (ab == code_cur);

  // Select the expected two-digit code for the current stage.
  always_comb begin
    code_cur = 8'h00;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (stage == SW'(i)) code_cur = CODE[i*8 +: 8];
    end
  end

  // State and datapath registers; enter_q resets high so a held button is not an edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_ENTRY;
      stage   <= '0;
      match   <= 1'b1;
      fails   <= 4'd0;
      timer   <= '0;
      enter_q <= 1'b1;
    end else begin
      state   <= state_nxt;
      stage   <= stage_nxt;
      match   <= match_nxt;
      fails   <= fails_nxt;
      timer   <= timer_nxt;
      enter_q <= enter;
    end
  end

  // Next-state logic; a mismatch is only judged once the last stage is entered.
  always_comb begin
    state_nxt = state;
    stage_nxt = stage;
    match_nxt = match;
    fails_nxt = fails;
    timer_nxt = timer;
    case (state)
      ST_ENTRY: begin
        if (enter_edge) begin
          if (ab == 8'h00) begin
            stage_nxt = '0;
            match_nxt = 1'b1;
          end else if (stage < LAST_STAGE) begin
            match_nxt = match & digit_ok;
            stage_nxt = stage + 1'b1;
          end else begin
            stage_nxt = '0;
            match_nxt = 1'b1;
            if (match && digit_ok) begin
              state_nxt = ST_UNLOCKED;
              fails_nxt = 4'd0;
            end else if (fails + 4'd1 == FAIL_LIMIT) begin
              state_nxt = ST_LOCKOUT;
              timer_nxt = LOCK_LOAD;
            end else begin
              state_nxt = ST_ERROR;
              fails_nxt = fails + 4'd1;
              timer_nxt = ERR_LOAD;
            end
          end
        end
      end
      ST_UNLOCKED: begin
        if (enter_edge && ab == 8'h00) state_nxt = ST_ENTRY;
      end
      ST_ERROR: begin
        if (timer == '0) state_nxt = ST_ENTRY;
        else             timer_nxt = timer - 1'b1;
      end
      ST_LOCKOUT: begin
        if (timer == '0) begin
          state_nxt = ST_ENTRY;
          fails_nxt = 4'd0;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      default: state_nxt = ST_ENTRY;
    endcase
  end

  logic [6:0] stage_seg_n;
  logic [6:0] msg6, msg5, msg4;

  hex_to_seg7 u_seg_b     (.hex(B),          .seg_n(H1));
  hex_to_seg7 u_seg_a     (.hex(A),          .seg_n(H2));
  hex_to_seg7 u_seg_stage (.hex(4'(stage)),  .seg_n(stage_seg_n));

  // Status word on the upper three digits, chosen by state.
  always_comb begin
    msg6 = SEG_BLANK;
    msg5 = SEG_BLANK;
    msg4 = SEG_BLANK;
    case (state)
      ST_UNLOCKED: begin msg6 = SEG_O; msg5 = SEG_P; msg4 = SEG_N; end
      ST_ERROR:    begin msg6 = SEG_E; msg5 = SEG_R; msg4 = SEG_R; end
      ST_LOCKOUT:  begin msg6 = SEG_L; msg5 = SEG_O; msg4 = SEG_C; end
      default:     begin msg6 = SEG_BLANK; msg5 = SEG_BLANK; msg4 = SEG_BLANK; end
    endcase
  end

  assign H3         = (state == ST_ENTRY) ? stage_seg_n : ~SEG_BLANK;
  assign H4         = ~msg4;
  assign H5         = ~msg5;
  assign H6         = ~msg6;
  assign unlocked   = (state == ST_UNLOCKED);
  assign locked_out = (state == ST_LOCKOUT);

endmodule
